// File: rtl/huffman_pkg.sv
// Shared Huffman constants: alphabet size, code geometry, table entry layout and FSM encodings.
// Used by the decoder, the frequency sorter and the future encoder.
package huffman_pkg;

  localparam int NSYM     = 4;
  localparam int MAXLEN   = 3;
  localparam int LENW     = 2;
  localparam int SYMW     = 2;
  localparam int ENTRY_W  = 5;
  localparam int CODE_LSB = 0;
  localparam int LEN_LSB  = 3;
  localparam int TABLE_W  = NSYM * ENTRY_W;

  typedef struct packed {
    logic [LENW-1:0]   len;
    logic [MAXLEN-1:0] code;
  } entry_t;

  localparam logic [0:0] ST_NOTABLE = 1'b0;
  localparam logic [0:0] ST_DECODE  = 1'b1;

endpackage

// File: rtl/huffman_code_match.sv
// Combinational lookup of the partial code against every table entry;
// reports a hit and the lowest matching symbol index.
module huffman_code_match
  import huffman_pkg::*;
#(
  parameter int NSYM   = huffman_pkg::NSYM,
  parameter int MAXLEN = huffman_pkg::MAXLEN,
  parameter int LENW   = huffman_pkg::LENW
) (
  input  logic [NSYM*(LENW+MAXLEN)-1:0] i_table,
  input  logic [MAXLEN-1:0]             i_partial,
  input  logic [$clog2(MAXLEN+1)-1:0]   i_count,
  output logic                          o_hit,
  output logic [$clog2(NSYM)-1:0]       o_idx
);

  localparam int EW   = LENW + MAXLEN;
  localparam int SYMW = $clog2(NSYM);

  logic [NSYM-1:0]   w_match;
  logic [MAXLEN-1:0] w_mask;

  // Only the low `count` bits of the partial register hold the code so far.
  assign w_mask = MAXLEN'((1 << i_count) - 1);

  generate
    for (genvar gi = 0; gi < NSYM; gi++) begin : g_entry
      logic [LENW-1:0]   w_len;
      logic [MAXLEN-1:0] w_code;
      assign w_len  = i_table[gi*EW+MAXLEN +: LENW];
      assign w_code = i_table[gi*EW +: MAXLEN];
      assign w_match[gi] = (i_count != '0) && (int'(w_len) == int'(i_count)) &&
                           ((w_code & w_mask) == (i_partial & w_mask));
    end
  endgenerate

  always_comb begin
    o_hit = |w_match;
    o_idx = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (w_match[i]) o_idx = SYMW'(i);
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial prefix-code decoder: gathers MSB-first bits, emits one symbol per
// completed code through a valid/ready output, and flags codes that never match.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int NSYM   = huffman_pkg::NSYM,
  parameter int MAXLEN = huffman_pkg::MAXLEN,
  parameter int LENW   = huffman_pkg::LENW
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NSYM*(LENW+MAXLEN)-1:0] TABLE_IN,
  input  logic                          TABLE_LOAD,
  input  logic                          BIT_IN,
  input  logic                          BIT_VALID,
  output logic                          BIT_READY,
  input  logic                          FLUSH,
  output logic [$clog2(NSYM)-1:0]       SYM_OUT,
  output logic                          SYM_VALID,
  input  logic                          SYM_READY,
  output logic                          CODE_ERR,
  output logic [15:0]                   SYM_COUNT
);

  localparam int TW   = NSYM * (LENW + MAXLEN);
  localparam int CW   = $clog2(MAXLEN + 1);
  localparam int SYMW = $clog2(NSYM);

  logic [0:0]        r_state;
  logic [TW-1:0]     r_table;
  logic [MAXLEN-1:0] r_partial;
  logic [CW-1:0]     r_count;
  logic [SYMW-1:0]   r_sym_out;
  logic              r_sym_valid;
  logic              r_code_err;
  logic [15:0]       r_sym_count;

  logic              w_accept;
  logic [MAXLEN-1:0] w_partial_upd;
  logic [CW-1:0]     w_count_upd;
  logic              w_hit;
  logic [SYMW-1:0]   w_idx;

  assign BIT_READY     = (r_state == ST_DECODE) && (!r_sym_valid || SYM_READY);
  assign w_accept      = BIT_VALID && BIT_READY;
  assign w_partial_upd = {r_partial[MAXLEN-2:0], BIT_IN};
  assign w_count_upd   = r_count + 1'b1;

  huffman_code_match #(
    .NSYM  (NSYM),
    .MAXLEN(MAXLEN),
    .LENW  (LENW)
  ) u_match (
    .i_table  (r_table),
    .i_partial(w_partial_upd),
    .i_count  (w_count_upd),
    .o_hit    (w_hit),
    .o_idx    (w_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_NOTABLE;
      r_table     <= '0;
      r_partial   <= '0;
      r_count     <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_code_err  <= 1'b0;
      r_sym_count <= '0;
    end else if (TABLE_LOAD) begin
      r_state     <= ST_DECODE;
      r_table     <= TABLE_IN;
      r_partial   <= '0;
      r_count     <= '0;
      r_sym_valid <= 1'b0;
      r_code_err  <= 1'b0;
      r_sym_count <= '0;
    end else begin
      r_code_err <= 1'b0;
      if (r_sym_valid && SYM_READY) r_sym_valid <= 1'b0;
      // A flush drops whatever bit arrives alongside it.
      if (FLUSH) begin
        r_partial <= '0;
        r_count   <= '0;
      end else if (w_accept) begin
        if (w_hit) begin
          r_sym_out   <= w_idx;
          r_sym_valid <= 1'b1;
          r_partial   <= '0;
          r_count     <= '0;
          r_sym_count <= r_sym_count + 16'd1;
        end else if (w_count_upd == CW'(MAXLEN)) begin
          r_code_err <= 1'b1;
          r_partial  <= '0;
          r_count    <= '0;
        end else begin
          r_partial <= w_partial_upd;
          r_count   <= w_count_upd;
        end
      end
    end
  end

  assign SYM_OUT   = r_sym_out;
  assign SYM_VALID = r_sym_valid;
  assign CODE_ERR  = r_code_err;
  assign SYM_COUNT = r_sym_count;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: table-driven bit stream plus directed
// sequences; emitted symbols are checked against a scoreboard queue.
module tb_huffman_decoder;

  localparam int NONE = -1;
  localparam int ERR  = -2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [19:0] TABLE_IN = '0;
  logic        TABLE_LOAD = 1'b0;
  logic        BIT_IN = 1'b0;
  logic        BIT_VALID = 1'b0;
  logic        BIT_READY;
  logic        FLUSH = 1'b0;
  logic [1:0]  SYM_OUT;
  logic        SYM_VALID;
  logic        SYM_READY = 1'b1;
  logic        CODE_ERR;
  logic [15:0] SYM_COUNT;

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  typedef struct {
    logic b;
    int   exp;
  } vec_t;

  vec_t vecs[9];

  huffman_decoder dut (
    .CLK       (CLK),
    .RST       (RST),
    .TABLE_IN  (TABLE_IN),
    .TABLE_LOAD(TABLE_LOAD),
    .BIT_IN    (BIT_IN),
    .BIT_VALID (BIT_VALID),
    .BIT_READY (BIT_READY),
    .FLUSH     (FLUSH),
    .SYM_OUT   (SYM_OUT),
    .SYM_VALID (SYM_VALID),
    .SYM_READY (SYM_READY),
    .CODE_ERR  (CODE_ERR),
    .SYM_COUNT (SYM_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [19:0] t);
    TABLE_IN   = t;
    TABLE_LOAD = 1'b1;
    tick();
    TABLE_LOAD = 1'b0;
  endtask

  // Offer one bit, wait (bounded) for acceptance, then check the result of that edge.
  task automatic send_bit(input logic b, input int exp);
    int n = 0;
    BIT_IN    = b;
    BIT_VALID = 1'b1;
    while (!BIT_READY && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("bit_ready_timeout", 0, 1);
    if (exp >= 0) sb_q.push_back(exp);
    tick();
    BIT_VALID = 1'b0;
    check("code_err", int'(CODE_ERR), (exp == ERR) ? 1 : 0);
    if (exp >= 0) begin
      check("sym_valid", int'(SYM_VALID), 1);
      check("sym_out", int'(SYM_OUT), exp);
    end else if (SYM_READY) begin
      check("no_sym_valid", int'(SYM_VALID), 0);
    end
  endtask

  // Scoreboard: every handshake pops the oldest expected symbol.
  always @(negedge CLK) begin
    if (!RST && SYM_VALID === 1'b1 && SYM_READY) begin
      if (sb_q.size() == 0) begin
        check("unexpected_sym", int'(SYM_OUT), NONE);
      end else begin
        check("sb_sym", int'(SYM_OUT), sb_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{b: 1'b0, exp: 0};
    vecs[1] = '{b: 1'b1, exp: NONE};
    vecs[2] = '{b: 1'b0, exp: 1};
    vecs[3] = '{b: 1'b1, exp: NONE};
    vecs[4] = '{b: 1'b1, exp: NONE};
    vecs[5] = '{b: 1'b0, exp: 2};
    vecs[6] = '{b: 1'b1, exp: NONE};
    vecs[7] = '{b: 1'b1, exp: NONE};
    vecs[8] = '{b: 1'b1, exp: 3};

    tick();
    tick();
    RST = 1'b0;
    check("rst_bit_ready", int'(BIT_READY), 0);
    check("rst_sym_valid", int'(SYM_VALID), 0);
    check("rst_sym_out", int'(SYM_OUT), 0);
    check("rst_code_err", int'(CODE_ERR), 0);
    check("rst_sym_count", int'(SYM_COUNT), 0);

    // No table yet: bits are refused and nothing comes out.
    BIT_IN = 1'b0;
    BIT_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("notable_bit_ready", int'(BIT_READY), 0);
      check("notable_sym_valid", int'(SYM_VALID), 0);
    end
    BIT_VALID = 1'b0;

    // Basic stream through the full table.
    load(20'hFFA48);
    for (int i = 0; i < 9; i++) send_bit(vecs[i].b, vecs[i].exp);
    tick();
    check("count_after_stream", int'(SYM_COUNT), 4);

    // Backpressure: second code must wait until the first symbol is taken.
    SYM_READY = 1'b0;
    send_bit(1'b1, NONE);
    send_bit(1'b0, 1);
    BIT_IN = 1'b1;
    BIT_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_bit_ready", int'(BIT_READY), 0);
      check("bp_sym_valid", int'(SYM_VALID), 1);
      check("bp_sym_out", int'(SYM_OUT), 1);
      tick();
    end
    SYM_READY = 1'b1;
    #1;
    check("bp_release_ready", int'(BIT_READY), 1);
    tick();
    BIT_VALID = 1'b0;
    check("bp_taken", int'(SYM_VALID), 0);
    send_bit(1'b0, 1);
    tick();
    check("bp_count", int'(SYM_COUNT), 6);

    // Unused symbol 3: "111" is an error pulse, then "0" still decodes.
    load(20'h07A48);
    send_bit(1'b1, NONE);
    send_bit(1'b1, NONE);
    send_bit(1'b1, ERR);
    tick();
    check("err_one_cycle", int'(CODE_ERR), 0);
    check("err_no_sym", int'(SYM_VALID), 0);
    send_bit(1'b0, 0);

    // Flush drops "11" and the bit offered alongside it.
    load(20'hFFA48);
    send_bit(1'b1, NONE);
    send_bit(1'b1, NONE);
    FLUSH = 1'b1;
    BIT_IN = 1'b0;
    BIT_VALID = 1'b1;
    tick();
    FLUSH = 1'b0;
    BIT_VALID = 1'b0;
    check("flush_no_sym", int'(SYM_VALID), 0);
    send_bit(1'b0, 0);
    tick();
    check("flush_count", int'(SYM_COUNT), 1);

    // Reset mid-code, reload, decode.
    send_bit(1'b1, NONE);
    send_bit(1'b1, NONE);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst2_bit_ready", int'(BIT_READY), 0);
    check("rst2_count", int'(SYM_COUNT), 0);
    load(20'hFFA48);
    send_bit(1'b0, 0);
    tick();
    check("rst2_sym_count", int'(SYM_COUNT), 1);

    // Table load discards a pending symbol and the counter.
    SYM_READY = 1'b0;
    send_bit(1'b0, 0);
    check("pend_count", int'(SYM_COUNT), 2);
    load(20'hFFA48);
    sb_q.delete();
    check("load_clears_valid", int'(SYM_VALID), 0);
    check("load_clears_count", int'(SYM_COUNT), 0);
    SYM_READY = 1'b1;
    tick();
    tick();

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 Parameter NSYM, default 4: number of alphabet symbols; symbol index width is 2.
REQ-002 Parameter MAXLEN, default 3: maximum code length in bits.
REQ-003 Parameter LENW, default 2: width of each per-symbol length field.
REQ-004 CLK  input  1  sole clock, rising-edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 TABLE_IN  input  20  code table; entry i at bits [5i+4:5i] = {len[1:0], code[2:0]}; code right-aligned; len 0 means symbol unused.
REQ-007 TABLE_LOAD  input  1  one-cycle strobe; captures TABLE_IN.
REQ-008 BIT_IN  input  1  next coded bit, MSB of each code first.
REQ-009 BIT_VALID  input  1  BIT_IN valid.
REQ-010 BIT_READY  output  1  decoder accepts a bit this cycle.
REQ-011 FLUSH  input  1  discard any partial code.
REQ-012 SYM_OUT  output  2  decoded symbol index.
REQ-013 SYM_VALID  output  1  SYM_OUT valid; held until taken.
REQ-014 SYM_READY  input  1  downstream takes SYM_OUT.
REQ-015 CODE_ERR  output  1  one-cycle pulse: MAXLEN bits gathered with no match.
REQ-016 SYM_COUNT  output  16  symbols emitted since reset or table load; wraps at 0xFFFF->0.

Function
REQ-017 States: NOTABLE (after reset, BIT_READY=0), DECODE; TABLE_LOAD moves any state to DECODE.
REQ-018 BIT_READY = (state==DECODE) && (!SYM_VALID || SYM_READY); a bit is accepted only when BIT_VALID && BIT_READY.
REQ-019 Accepted bit shifts into LSB of a 3-bit partial register; bit counter increments 0..3.
REQ-020 Match is evaluated combinationally on the updated partial (count c): entry i matches if len_i==c and code_i[c-1:0]==partial[c-1:0].
REQ-021 On match: SYM_OUT<=lowest matching index, SYM_VALID<=1 on the next edge (1-cycle latency), partial and count cleared, SYM_COUNT incremented.
REQ-022 No match and c==MAXLEN: CODE_ERR=1 for the next cycle only, partial and count cleared, no symbol emitted.
REQ-023 No match and c<MAXLEN: keep accumulating.
REQ-024 SYM_VALID clears when SYM_READY=1 unless a new symbol completes the same cycle, in which case SYM_VALID stays 1 with the new SYM_OUT (back-to-back, no bubble).
REQ-025 SYM_OUT and SYM_VALID stay stable while SYM_VALID && !SYM_READY.
REQ-026 FLUSH clears partial and count; any bit accepted in the same cycle is dropped; a pending SYM_VALID is unaffected.
REQ-027 TABLE_LOAD has priority over bit, flush and output activity: clears partial, count, SYM_VALID, CODE_ERR and SYM_COUNT.
REQ-028 Table with all len 0: every third accepted bit yields CODE_ERR; no symbols emitted.

Reset
REQ-029 On RST=1 at a CLK edge: state NOTABLE, table cleared to 0, partial=0, count=0, SYM_OUT=0, SYM_VALID=0, CODE_ERR=0, SYM_COUNT=0, BIT_READY=0.
REQ-030 RST has priority over TABLE_LOAD; reset mid-code discards the partial code and pending symbol.

Structure
REQ-031 A shared huffman package holds NSYM, MAXLEN, LENW, entry width 5, and the entry field offsets, for use with the frequency sorter and the future encoder.
REQ-032 One sub-module, huffman_code_match: combinational, takes the table, partial and count, and returns hit and index; it is instantiated once.
REQ-033 All outputs are registered except BIT_READY.

Verification
REQ-034 RST, then load TABLE_IN=0xFFA48 (0="0", 1="10", 2="110", 3="111"); stream 0,1,0,1,1,0,1,1,1 with SYM_READY=1 -> SYM_OUT 0,1,2,3, each valid 1 cycle after its last bit; SYM_COUNT=4.
REQ-035 Same table, SYM_READY=0, stream 1,0,1,0 -> SYM_VALID=1, SYM_OUT=1 held; BIT_READY=0 after the 2nd bit; raise SYM_READY -> second 1 delivered, nothing lost.
REQ-036 TABLE_IN=0x07A48 (symbol 3 unused), stream 1,1,1 -> CODE_ERR pulses 1 cycle, no SYM_VALID; then 0 -> SYM_OUT=0.
REQ-037 Stream 1,1, then FLUSH, then 0 -> SYM_OUT=0; no symbol 2 or 3.
REQ-038 Before any TABLE_LOAD -> BIT_READY=0, no outputs; RST after 2 bits of "110" then load and feed 0 -> SYM_OUT=0, SYM_COUNT=1.
REQ-039 TABLE_LOAD while SYM_VALID=1 pending -> SYM_VALID=0 and SYM_COUNT=0 the next cycle.
